cp0_unit: RTL and testbench

Coprocessor-0 for the P7 pipelined MIPS core, located at the M stage. It consumes the per-instruction exception metadata (ExcCode, branch-delay flag, PC) that travels down the pipeline registers, plus the six external hardware interrupt lines. It produces the pipeline-wide flush request `Req` and the saved return address `EPCOut` for `eret`. It also implements `mtc0`/`mfc0` access to SR(12), Cause(13), EPC(14) and PRId(15).

---
 rtl/cp0_pkg.sv | 36 +++
 rtl/cp0_unit.sv | 111 +++++++++++
 tb/tb_cp0_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 block: register numbers, SR/Cause
// field positions, exception codes and the handler entry point.
// Pure constants; no logic and no state.
package cp0_pkg;

    // CP0 register numbers addressable by mtc0/mfc0
    localparam logic [4:0] CP0_REG_SR    = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
    localparam logic [4:0] CP0_REG_EPC   = 5'd14;
    localparam logic [4:0] CP0_REG_PRID  = 5'd15;

    // SR field positions
    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int SR_IM_LO = 10;
    localparam int SR_IM_HI = 15;

    // Cause field positions
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    // ExcCode values carried down the pipeline
    localparam logic [4:0] EXC_CODE_INT     = 5'd0;
    localparam logic [4:0] EXC_CODE_ADEL    = 5'd4;
    localparam logic [4:0] EXC_CODE_ADES    = 5'd5;
    localparam logic [4:0] EXC_CODE_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_CODE_RI      = 5'd10;
    localparam logic [4:0] EXC_CODE_OV      = 5'd12;

    // Exception/interrupt handler entry address used by the fetch redirect
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor-0 at the M stage: SR/Cause/EPC/PRId plus exception and interrupt
// request generation. Req is combinational in the cause cycle; register updates
// appear on CP0Out/EPCOut one cycle later. No backpressure; Req flushes F/D/E/M.
// Ports: clk/rst (async active-low); en/CP0Add/CP0In/CP0Out for mtc0/mfc0;
// VPC/BDIn/ExcCodeIn/HWInt/EXLClr exception inputs; Req and EPCOut to the pipeline.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID    = 32'h2023_0007,
    parameter logic [4:0]  EXC_INT = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    // SR fields
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    // Cause fields
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    // EPC is always word aligned, so only the upper 30 bits are stored
    logic [31:2] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic [31:2] w_epc_entry;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic        w_unused_vpc;

    assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
    assign Req       = w_int_req | w_exc_req;

    // A delay-slot instruction restarts at its branch, one word earlier
    assign w_epc_entry  = BDIn ? (VPC[31:2] - 30'd1) : VPC[31:2];
    assign w_unused_vpc = ^VPC[1:0];

    always_comb begin
        w_sr                          = '0;
        w_sr[SR_IM_HI:SR_IM_LO]       = r_im;
        w_sr[SR_EXL]                  = r_exl;
        w_sr[SR_IE]                   = r_ie;
        w_cause                       = '0;
        w_cause[CAUSE_BD]             = r_bd;
        w_cause[CAUSE_IP_HI:CAUSE_IP_LO]   = r_ip;
        w_cause[CAUSE_EXC_HI:CAUSE_EXC_LO] = r_exccode;
    end

    always_comb begin
        CP0Out = '0;
        case (CP0Add)
            CP0_REG_SR:    CP0Out = w_sr;
            CP0_REG_CAUSE: CP0Out = w_cause;
            CP0_REG_EPC:   CP0Out = {r_epc, 2'b00};
            CP0_REG_PRID:  CP0Out = PRID;
            default:       CP0Out = '0;
        endcase
    end

    assign EPCOut = {r_epc, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= '0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            // Pending lines are sampled every cycle, exception entry or not
            r_ip <= HWInt;
            if (Req) begin
                // Exception entry wins over any coincident mtc0 or eret
                r_exl     <= 1'b1;
                r_bd      <= BDIn;
                r_exccode <= w_int_req ? EXC_INT : ExcCodeIn;
                r_epc     <= w_epc_entry;
            end else begin
                if (en && (CP0Add == CP0_REG_SR)) begin
                    r_im  <= CP0In[SR_IM_HI:SR_IM_LO];
                    r_ie  <= CP0In[SR_IE];
                    // eret in the same cycle still leaves EXL clear
                    r_exl <= CP0In[SR_EXL] & ~EXLClr;
                end else if (EXLClr) begin
                    r_exl <= 1'b0;
                end
                if (en && (CP0Add == CP0_REG_EPC)) begin
                    r_epc <= CP0In[31:2];
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    int checks;
    int errors;

    // Architectural reference state
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    cp0_unit dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .CP0Add    (CP0Add),
        .CP0In     (CP0In),
        .CP0Out    (CP0Out),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_int();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h2023_0007;
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle_inputs();
        en = 0; CP0Add = 5'd0; CP0In = 0; BDIn = 0; ExcCodeIn = 0;
        HWInt = 0; EXLClr = 0;
    endtask

    // Advance one clock edge, updating the reference from the architectural rules.
    task automatic cycle();
        logic [31:0] nsr, ncause, nepc, base;
        nsr = m_sr; ncause = m_cause; nepc = m_epc;
        base = {VPC[31:2], 2'b00};
        ncause[15:10] = HWInt;
        if (m_req()) begin
            nsr[1]       = 1'b1;
            ncause[31]   = BDIn;
            ncause[6:2]  = m_int() ? 5'd0 : ExcCodeIn;
            nepc         = BDIn ? base - 32'd4 : base;
        end else begin
            if (en && CP0Add == 5'd12) nsr = CP0In & 32'h0000_fc03;
            if (en && CP0Add == 5'd14) nepc = {CP0In[31:2], 2'b00};
            if (EXLClr) nsr[1] = 1'b0;
        end
        @(posedge clk);
        m_sr = nsr; m_cause = ncause; m_epc = nepc;
        #1;
    endtask

    task automatic test_reset();
        rst = 0; idle_inputs(); VPC = 32'h0000_3000;
        m_sr = 0; m_cause = 0; m_epc = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1;
        @(negedge clk);
        for (int a = 12; a <= 15; a++) begin
            CP0Add = 5'(a); #1;
            checks++;
            if (CP0Out !== m_read(5'(a))) begin
                errors++; $display("FAIL reset_read%0d got %h want %h", a, CP0Out, m_read(5'(a)));
            end
        end
        checks++;
        if (Req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", Req); end
        cycle();
    endtask

    task automatic test_mtc0_sr();
        en = 1; CP0Add = 5'd12; CP0In = 32'hffff_ffff; #1;
        cycle();
        en = 0; #1;
        checks++;
        if (CP0Out !== 32'h0000_fc03) begin errors++; $display("FAIL sr_write got %h want %h", CP0Out, 32'h0000_fc03); end
        // Reopen interrupts: IE=1, IM=all, EXL=0
        en = 1; CP0In = 32'h0000_fc01; #1;
        cycle();
        en = 0; VPC = 32'h0000_3040; HWInt = 6'b000100; #1;
        checks++;
        if (Req !== 1'b1) begin errors++; $display("FAIL int_req got %b want 1", Req); end
        cycle();
        CP0Add = 5'd13; #1;
        checks++;
        if (CP0Out !== 32'h0000_1000) begin errors++; $display("FAIL int_cause got %h want %h", CP0Out, 32'h0000_1000); end
        checks++;
        if (EPCOut !== 32'h0000_3040) begin errors++; $display("FAIL int_epc got %h want %h", EPCOut, 32'h0000_3040); end
        checks++;
        if (Req !== 1'b0) begin errors++; $display("FAIL int_exl_masks got %b want 0", Req); end
        HWInt = 0; EXLClr = 1; #1;
        cycle();
        EXLClr = 0; #1;
    endtask

    task automatic test_delay_slot_exc();
        VPC = 32'h0000_3008; BDIn = 1; ExcCodeIn = 5'd12; #1;
        checks++;
        if (Req !== 1'b1) begin errors++; $display("FAIL ds_req got %b want 1", Req); end
        cycle();
        VPC = 32'h0000_300c; BDIn = 0; ExcCodeIn = 5'd4; CP0Add = 5'd13; #1;
        checks++;
        if (EPCOut !== 32'h0000_3004) begin errors++; $display("FAIL ds_epc got %h want %h", EPCOut, 32'h0000_3004); end
        checks++;
        if (CP0Out[31] !== 1'b1 || CP0Out[6:2] !== 5'd12) begin
            errors++; $display("FAIL ds_cause got %h want BD=1 code=12", CP0Out);
        end
        CP0Add = 5'd12; #1;
        checks++;
        if (CP0Out[1] !== 1'b1) begin errors++; $display("FAIL ds_exl got %b want 1", CP0Out[1]); end
        checks++;
        if (Req !== 1'b0) begin errors++; $display("FAIL ds_nested got %b want 0", Req); end
        cycle();
        ExcCodeIn = 0; #1;
    endtask

    task automatic test_int_vs_exc();
        // mtc0 SR together with eret: written value lands, EXL still ends clear
        en = 1; CP0Add = 5'd12; CP0In = 32'h0000_fc03; EXLClr = 1; #1;
        cycle();
        en = 0; EXLClr = 0; #1;
        checks++;
        if (CP0Out !== 32'h0000_fc01) begin errors++; $display("FAIL sr_eret got %h want %h", CP0Out, 32'h0000_fc01); end
        VPC = 32'h0000_3100; HWInt = 6'b000001; ExcCodeIn = 5'd10; #1;
        checks++;
        if (Req !== 1'b1) begin errors++; $display("FAIL both_req got %b want 1", Req); end
        cycle();
        HWInt = 0; ExcCodeIn = 0; CP0Add = 5'd13; #1;
        checks++;
        if (CP0Out[6:2] !== 5'd0) begin errors++; $display("FAIL both_code got %h want 0", CP0Out[6:2]); end
        EXLClr = 1; #1;
        cycle();
        EXLClr = 0; #1;
    endtask

    task automatic test_epc_write();
        VPC = 32'h0000_4000; ExcCodeIn = 5'd8; en = 1; CP0Add = 5'd14; CP0In = 32'h0000_3011; #1;
        cycle();
        en = 0; ExcCodeIn = 0; #1;
        checks++;
        if (EPCOut !== 32'h0000_4000) begin errors++; $display("FAIL epc_dropped got %h want %h", EPCOut, 32'h0000_4000); end
        EXLClr = 1; #1;
        cycle();
        EXLClr = 0; en = 1; #1;
        cycle();
        en = 0; #1;
        checks++;
        if (EPCOut !== 32'h0000_3010) begin errors++; $display("FAIL epc_write got %h want %h", EPCOut, 32'h0000_3010); end
    endtask

    task automatic test_eret();
        // Enter an exception to set EXL, then eret with a pending interrupt
        VPC = 32'h0000_5000; ExcCodeIn = 5'd5; #1;
        cycle();
        ExcCodeIn = 0; HWInt = 6'b000001; EXLClr = 1; #1;
        checks++;
        if (Req !== 1'b0) begin errors++; $display("FAIL eret_req got %b want 0", Req); end
        cycle();
        EXLClr = 0; CP0Add = 5'd12; #1;
        checks++;
        if (CP0Out[1] !== 1'b0) begin errors++; $display("FAIL eret_exl got %b want 0", CP0Out[1]); end
        checks++;
        if (Req !== 1'b1) begin errors++; $display("FAIL eret_pending got %b want 1", Req); end
        cycle();
        HWInt = 0; #1;
    endtask

    task automatic test_mid_reset();
        en = 1; CP0Add = 5'd12; CP0In = 32'h0000_fc01; #1;
        cycle();
        en = 0; #1;
        rst = 0; #1;
        m_sr = 0; m_cause = 0; m_epc = 0;
        for (int a = 12; a <= 14; a++) begin
            CP0Add = 5'(a); #1;
            checks++;
            if (CP0Out !== 32'h0) begin errors++; $display("FAIL midrst_read%0d got %h want 0", a, CP0Out); end
        end
        checks++;
        if (Req !== 1'b0 || EPCOut !== 32'h0) begin
            errors++; $display("FAIL midrst_out got req=%b epc=%h want 0/0", Req, EPCOut);
        end
        @(negedge clk);
        rst = 1;
        cycle();
    endtask

    task automatic test_random();
        logic [4:0] codes [8];
        codes = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 2) == 0);
            CP0Add    = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            CP0In     = $urandom;
            VPC       = $urandom;
            BDIn      = 1'($urandom);
            ExcCodeIn = codes[$urandom_range(0, 7)];
            HWInt     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            EXLClr    = ($urandom_range(0, 4) == 0);
            #1;
            checks++;
            if (Req !== m_req()) begin errors++; $display("FAIL rnd_req[%0d] got %b want %b", i, Req, m_req()); end
            checks++;
            if (CP0Out !== m_read(CP0Add)) begin
                errors++; $display("FAIL rnd_read[%0d] addr %0d got %h want %h", i, CP0Add, CP0Out, m_read(CP0Add));
            end
            checks++;
            if (EPCOut !== m_epc) begin errors++; $display("FAIL rnd_epc[%0d] got %h want %h", i, EPCOut, m_epc); end
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mtc0_sr();
        test_delay_slot_exc();
        test_int_vs_exc();
        test_epc_write();
        test_eret();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
